// File: rtl/neuron_pkg.sv
// Shared types and helpers for the time-multiplexed fixed-point neuron.
// Holds the FSM state enum, the accumulator-width rule and the output saturator.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Working width for the saturator; wide enough for any practical ACC_W.
    localparam int SAT_W = 128;

    typedef struct packed {
        logic             sat;
        logic [SAT_W-1:0] value;
    } sat_res_t;

    function automatic int acc_width(input int dw, input int n_in);
        return 2 * dw + $clog2(n_in + 1);
    endfunction

    // Clip a sign-extended value to the signed dw-bit range and flag clipping.
    function automatic sat_res_t saturate(input logic signed [SAT_W-1:0] v, input int dw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t                r;
        hi      = (SAT_W'(1) <<< (dw - 1)) - SAT_W'(1);
        lo      = ~hi;
        r.sat   = 1'b0;
        r.value = v;
        if (v > hi) begin
            r.value = hi;
            r.sat   = 1'b1;
        end else if (v < lo) begin
            r.value = lo;
            r.sat   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_mac_unit.sv
// Single signed DWxDW multiplier feeding an ACC_W accumulator.
// load overrides en, so a new computation can start from the bias in one cycle.
module neuron_mac_unit #(
    parameter int DW    = 16,
    parameter int ACC_W = 36
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic signed [ACC_W-1:0] load_val,
    input  logic                    en,
    input  logic signed [DW-1:0]    a,
    input  logic signed [DW-1:0]    b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*DW-1:0]  a_ext;
    logic signed [2*DW-1:0]  b_ext;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;

    assign a_ext    = {{DW{a[DW-1]}}, a};
    assign b_ext    = {{DW{b[DW-1]}}, b};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (load) begin
            acc <= load_val;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron: bias + sum(x[i]*w[i]) over N_IN cycles, then rescale,
// saturate and optional ReLU. States: IDLE accept | ACCUM mac | RESULT register | HOLD output.
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int N_IN = 15,
    parameter int DW   = 16,
    parameter int FRAC = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       w_wr_en,
    input  logic [$clog2(N_IN+1)-1:0]  w_wr_addr,
    input  logic signed [DW-1:0]       w_wr_data,
    input  logic                       relu_en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_IN*DW-1:0]         in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DW-1:0]       out_data,
    output logic                       out_sat
);

    localparam int ACC_W = acc_width(DW, N_IN);
    localparam int IDX_W = $clog2(N_IN + 1);

    state_t state;
    state_t state_nxt;

    logic                    acc_load;
    logic                    mac_en;
    logic                    res_load;
    logic                    wr_ok;

    logic signed [DW-1:0]    w_mem [0:N_IN];
    logic [N_IN*DW-1:0]      x_q;
    logic                    relu_q;
    logic [IDX_W-1:0]        idx;

    logic signed [DW-1:0]    bias_eff;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] bias_acc;
    logic signed [DW-1:0]    x_cur;
    logic signed [DW-1:0]    w_cur;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] r_shift;
    sat_res_t                sat_res;
    logic signed [DW-1:0]    res_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        acc_load  = 1'b0;
        mac_en    = 1'b0;
        res_load  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = ~reset;
                if (in_valid) begin
                    acc_load  = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                mac_en = 1'b1;
                if (idx == IDX_W'(N_IN - 1)) begin
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                res_load  = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_ok = w_wr_en && (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= N_IN; i++) begin
                w_mem[i] <= '0;
            end
        end else if (wr_ok) begin
            for (int i = 0; i <= N_IN; i++) begin
                if (w_wr_addr == IDX_W'(i)) begin
                    w_mem[i] <= w_wr_data;
                end
            end
        end
    end

    // A bias write in the accept cycle must be seen by the accumulator load.
    assign bias_eff = (wr_ok && (w_wr_addr == IDX_W'(N_IN))) ? w_wr_data : w_mem[N_IN];
    assign bias_ext = {{(ACC_W-DW){bias_eff[DW-1]}}, bias_eff};
    assign bias_acc = bias_ext <<< FRAC;

    assign x_cur = x_q[idx*DW +: DW];
    assign w_cur = w_mem[idx];

    neuron_mac_unit #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .load     (acc_load),
        .load_val (bias_acc),
        .en       (mac_en),
        .a        (x_cur),
        .b        (w_cur),
        .acc      (acc)
    );

    assign r_shift = acc >>> FRAC;
    assign sat_res = saturate({{(SAT_W-ACC_W){r_shift[ACC_W-1]}}, r_shift}, DW);
    assign res_val = sat_res.value[DW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q       <= '0;
            relu_q    <= 1'b0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (acc_load) begin
                x_q    <= in_data;
                relu_q <= relu_en;
                idx    <= '0;
            end else if (mac_en && (idx != IDX_W'(N_IN - 1))) begin
                idx <= idx + IDX_W'(1);
            end
            if (res_load) begin
                out_valid <= 1'b1;
                out_sat   <= sat_res.sat;
                out_data  <= (relu_q && res_val[DW-1]) ? '0 : res_val;
            end else if ((state == HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
